// File: rtl/pmem_line_initiator.sv
// L1 miss-path initiator: optional victim writeback, then line fill.
// Define PMEM_INIT_TIMEOUT_EN for a per-phase timeout and sticky err flag.
module pmem_line_initiator #(
    parameter int ADDR_W      = 16,
    parameter int LINE_W      = 256,
    parameter int OFFSET_W    = 5,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_dirty,
    input  logic [ADDR_W-1:0] req_wb_addr,
    input  logic [LINE_W-1:0] req_wb_data,
    output logic              done,
    output logic [LINE_W-1:0] fill_data,
`ifdef PMEM_INIT_TIMEOUT_EN
    output logic              err,
`endif
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WB,
        GAP,
        FILL,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LINE_MASK =
        {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] fill_addr_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [LINE_W-1:0] wb_data_q;
    logic [LINE_W-1:0] fill_q;
    logic              accept;
    logic              in_phase;
    logic              timeout;

    assign accept     = req_valid & req_ready;
    assign in_phase   = (state_q == WB) || (state_q == FILL);
    assign pmem_wdata = wb_data_q;
    assign fill_data  = fill_q;

`ifdef PMEM_INIT_TIMEOUT_EN
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYC - 1);

    logic [9:0] wait_q;
    logic       err_q;

    // A response in the last allowed cycle still wins over the timeout.
    assign timeout = in_phase && !pmem_resp && (wait_q == TO_LAST);
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (in_phase && (state_d == state_q))
                wait_q <= wait_q + 10'd1;
            else
                wait_q <= '0;
            if (timeout)
                err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        req_ready    = 1'b0;
        done         = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_d = req_dirty ? WB : FILL;
            end
            WB: begin
                pmem_write   = 1'b1;
                pmem_address = wb_addr_q;
                if (pmem_resp)
                    state_d = GAP;
                else if (timeout)
                    state_d = DONE;
            end
            GAP: state_d = FILL;
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = fill_addr_q;
                if (pmem_resp || timeout)
                    state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fill_addr_q <= '0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            fill_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                fill_addr_q <= req_addr & LINE_MASK;
                wb_addr_q   <= req_wb_addr & LINE_MASK;
                wb_data_q   <= req_wb_data;
            end
            if ((state_q == FILL) && pmem_resp)
                fill_q <= pmem_rdata;
            else if (timeout)
                fill_q <= '0;
        end
    end

endmodule

// File: tb/tb_pmem_line_initiator.sv
// Testbench for pmem_line_initiator: per-transaction cycle plan built
// from the protocol rules, checked against the DUT every cycle.
module tb_pmem_line_initiator;

    localparam logic [15:0] MASK = 16'hFFE0;
    localparam int TO = 1023;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [15:0]  req_addr;
    logic         req_dirty;
    logic [15:0]  req_wb_addr;
    logic [255:0] req_wb_data;
    logic         done;
    logic [255:0] fill_data;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;
`ifdef PMEM_INIT_TIMEOUT_EN
    logic         err;
`endif

    always #5 clk = ~clk;

    pmem_line_initiator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_dirty    (req_dirty),
        .req_wb_addr  (req_wb_addr),
        .req_wb_data  (req_wb_data),
        .done         (done),
        .fill_data    (fill_data),
`ifdef PMEM_INIT_TIMEOUT_EN
        .err          (err),
`endif
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata)
    );

    // One entry per clock cycle: what the outputs must be, what to drive.
    typedef struct {
        bit           acc;
        bit           dirty;
        bit           rd;
        bit           wr;
        bit           dn;
        bit           ready;
        bit           resp;
        bit           cf;
        bit           er;
        logic [15:0]  a;
        logic [15:0]  wa;
        logic [15:0]  addr;
        logic [255:0] wd;
        logic [255:0] wdata;
        logic [255:0] rdata;
        logic [255:0] fill;
    } item_t;

    item_t        q[$];
    int           total = 0;
    int           bad = 0;
    logic [255:0] last_fill;
    bit           exp_err;
    bit           hold_valid;
    int           rd_cyc, gap_cyc, done_cnt;
    bit           seen_wr, seen_rd;
    logic [15:0]  first_raddr, first_waddr;
    logic [255:0] first_wdata;

    function automatic logic [255:0] rnd_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic item_t blank();
        item_t e;
        e = '{default: '0};
        e.er = exp_err;
        return e;
    endfunction

    task automatic chk(string n, logic [255:0] act, logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", n, $time, act, exp);
        end
    endtask

    task automatic clr_obs();
        rd_cyc = 0; gap_cyc = 0; done_cnt = 0;
        seen_wr = 0; seen_rd = 0;
        first_raddr = '0; first_waddr = '0; first_wdata = '0;
    endtask

    // Transaction -> cycle plan: idle cycles, accept, WB(dw+1), GAP,
    // FILL(dr+1), DONE.  Response arrives in the last cycle of a phase.
    task automatic push_txn(logic [15:0] a, bit dirty, logic [15:0] wa,
                            logic [255:0] wd, logic [255:0] rdv,
                            int dw, int dr, int idle);
        item_t e;
        for (int i = 0; i < idle; i++) begin
            e = blank(); e.ready = 1; e.cf = 1; e.fill = last_fill;
            q.push_back(e);
        end
        e = blank(); e.ready = 1; e.cf = 1; e.fill = last_fill;
        e.acc = 1; e.a = a; e.dirty = dirty; e.wa = wa; e.wd = wd;
        q.push_back(e);
        if (dirty) begin
            for (int k = 0; k <= dw; k++) begin
                e = blank(); e.wr = 1; e.addr = wa & MASK; e.wdata = wd;
                e.resp = (k == dw);
                q.push_back(e);
            end
            q.push_back(blank());
        end
        for (int k = 0; k <= dr; k++) begin
            e = blank(); e.rd = 1; e.addr = a & MASK;
            e.resp = (k == dr); e.rdata = rdv;
            q.push_back(e);
        end
        e = blank(); e.dn = 1; e.cf = 1; e.fill = rdv;
        q.push_back(e);
        last_fill = rdv;
    endtask

    task automatic step(item_t e);
        @(negedge clk);
        if (pmem_read) rd_cyc++;
        if (pmem_write && !seen_wr) begin
            seen_wr = 1; first_waddr = pmem_address; first_wdata = pmem_wdata;
        end
        if (pmem_read && !seen_rd) begin
            seen_rd = 1; first_raddr = pmem_address;
        end
        if (seen_wr && !seen_rd && !pmem_read && !pmem_write) gap_cyc++;
        if (done) done_cnt++;
        chk("pmem_read", 256'(pmem_read), 256'(e.rd));
        chk("pmem_write", 256'(pmem_write), 256'(e.wr));
        chk("done", 256'(done), 256'(e.dn));
        chk("req_ready", 256'(req_ready), 256'(e.ready));
        if (e.rd || e.wr) chk("pmem_address", 256'(pmem_address), 256'(e.addr));
        if (e.wr) chk("pmem_wdata", pmem_wdata, e.wdata);
        if (e.cf) chk("fill_data", fill_data, e.fill);
`ifdef PMEM_INIT_TIMEOUT_EN
        chk("err", 256'(err), 256'(e.er));
`endif
        if (e.acc) begin
            req_valid = 1; req_addr = e.a; req_dirty = e.dirty;
            req_wb_addr = e.wa; req_wb_data = e.wd;
        end else begin
            req_valid = e.ready ? 1'b0 : (hold_valid ? 1'b1 : 1'($urandom));
            req_addr = 16'($urandom); req_dirty = 1'($urandom);
            req_wb_addr = 16'($urandom); req_wb_data = rnd_line();
        end
        pmem_resp = (e.rd || e.wr) ? e.resp : ($urandom_range(0, 3) == 0);
        pmem_rdata = e.resp ? e.rdata : rnd_line();
    endtask

    task automatic run_all();
        item_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            step(e);
        end
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_ready"}, 256'(req_ready), 256'(1));
        chk({tag, "_read"}, 256'(pmem_read), 256'(0));
        chk({tag, "_write"}, 256'(pmem_write), 256'(0));
        chk({tag, "_done"}, 256'(done), 256'(0));
        chk({tag, "_addr"}, 256'(pmem_address), 256'(0));
        chk({tag, "_wdata"}, pmem_wdata, 256'(0));
        chk({tag, "_fill"}, fill_data, 256'(0));
`ifdef PMEM_INIT_TIMEOUT_EN
        chk({tag, "_err"}, 256'(err), 256'(0));
`endif
    endtask

    initial begin
        logic [255:0] a5;
        logic [255:0] wd;
        item_t        e;
        a5 = {32{8'hA5}};
        rst_n = 0; req_valid = 0; req_addr = '0; req_dirty = 0;
        req_wb_addr = '0; req_wb_data = '0; pmem_resp = 0; pmem_rdata = '0;
        last_fill = '0; exp_err = 0; hold_valid = 0;
        clr_obs();
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1;

        // clean miss, read held 25 cycles
        clr_obs();
        push_txn(16'h1234, 0, 16'h0, '0, a5, 0, 24, 0);
        run_all();
        chk("clean_rd_cycles", 256'(rd_cyc), 256'(25));
        chk("clean_raddr", 256'(first_raddr), 256'(16'h1220));
        chk("clean_no_write", 256'(seen_wr), 256'(0));
        chk("clean_done_cnt", 256'(done_cnt), 256'(1));
        chk("clean_fill", fill_data, a5);

        // dirty miss
        clr_obs();
        push_txn(16'h0080, 1, 16'h0040, 256'h1, rnd_line(), 3, 5, 1);
        run_all();
        chk("dirty_waddr", 256'(first_waddr), 256'(16'h0040));
        chk("dirty_wdata", first_wdata, 256'h1);
        chk("dirty_gap", 256'(gap_cyc), 256'(1));
        chk("dirty_raddr", 256'(first_raddr), 256'(16'h0080));
        chk("dirty_done_cnt", 256'(done_cnt), 256'(1));

        // response in the first writeback cycle
        clr_obs();
        push_txn(16'h3fff, 1, 16'h7ab3, rnd_line(), rnd_line(), 0, 2, 0);
        run_all();
        chk("early_gap", 256'(gap_cyc), 256'(1));
        chk("early_waddr", 256'(first_waddr), 256'(16'h7aa0));

        // back-to-back with req_valid held high throughout
        clr_obs();
        hold_valid = 1;
        push_txn(16'h1111, 0, 16'h0, '0, rnd_line(), 0, 4, 0);
        push_txn(16'h2222, 1, 16'h3333, rnd_line(), rnd_line(), 2, 1, 0);
        run_all();
        hold_valid = 0;
        chk("b2b_done_cnt", 256'(done_cnt), 256'(2));

`ifdef PMEM_INIT_TIMEOUT_EN
        // no response: fill phase times out
        e = blank(); e.ready = 1; e.cf = 1; e.fill = last_fill;
        e.acc = 1; e.a = 16'h0500;
        q.push_back(e);
        for (int k = 0; k < TO; k++) begin
            e = blank(); e.rd = 1; e.addr = 16'h0500;
            q.push_back(e);
        end
        exp_err = 1;
        e = blank(); e.dn = 1; e.cf = 1; e.fill = '0;
        q.push_back(e);
        last_fill = '0;
        run_all();
        chk("timeout_fill", fill_data, 256'(0));
`endif

        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            hold_valid = 1'($urandom);
            push_txn(16'($urandom), 1'($urandom), 16'($urandom), rnd_line(),
                     rnd_line(), $urandom_range(0, 12), $urandom_range(0, 12),
                     $urandom_range(0, 2));
            run_all();
        end
        hold_valid = 0;

        // reset in the middle of a fill
        clr_obs();
        wd = rnd_line() | 256'h1;
        push_txn(16'h4560, 1, 16'h6540, wd, rnd_line(), 2, 10, 0);
        for (int i = 0; i < 8; i++) begin
            e = q.pop_front();
            step(e);
        end
        q.delete();
        @(negedge clk);
        chk("mid_fill_read", 256'(pmem_read), 256'(1));
        rst_n = 0; pmem_resp = 0; req_valid = 0;
        @(negedge clk);
        chk_reset_vals("rst_mid");
        rst_n = 1; pmem_resp = 1; pmem_rdata = rnd_line();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pmem_resp = 0;
            chk("late_resp_done", 256'(done), 256'(0));
            chk("late_resp_read", 256'(pmem_read), 256'(0));
            chk("late_resp_ready", 256'(req_ready), 256'(1));
            chk("late_resp_fill", fill_data, 256'(0));
        end
        last_fill = '0; exp_err = 0;

        // recovery after reset
        push_txn(16'h0fe7, 0, 16'h0, '0, rnd_line(), 0, 3, 0);
        run_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
